// File: rtl/fwft_rr_pkg.sv
// Shared types and helpers for the FWFT round-robin drain logic.
// The state encoding is shared so that other arbiters can reuse it.
package fwft_rr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int STAT_WIDTH = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping modulo N.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] start;
  logic [N-1:0]  rot;
  logic [IW:0]   sum;

  always_comb begin
    start = (last >= IW'(N - 1)) ? '0 : last + 1'b1;
    // Rotating a doubled copy puts the search start at bit 0.
    rot   = N'({req, req} >> start);
    found = |rot;
    sum   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sum = {1'b0, start} + (IW + 1)'(i);
    end
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/fwft_rr_drain.sv
// Round-robin burst drainer for FWFT FIFO read ports; pop-to-output latency is one cycle.
// Pops stall while the output holds an unaccepted word; FWFT_RR_DRAIN_STATS_EN adds per-port pop counters.
module fwft_rr_drain
  import fwft_rr_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 16,
  parameter int SRC_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_has_data,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_rd_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SRC_WIDTH-1:0]            out_src,
`ifdef FWFT_RR_DRAIN_STATS_EN
  output logic [NUM_PORTS*STAT_WIDTH-1:0] stat_words,
`endif
  output logic                            busy
);

  localparam int CW = clog2(BURST) + 1;

  state_e                state_q, state_d;
  logic [SRC_WIDTH-1:0]  grant_q, grant_d;
  logic [SRC_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_WIDTH-1:0]  out_src_q, out_src_d;

  logic                  pick_found;
  logic [SRC_WIDTH-1:0]  pick_idx;
  logic                  head_vld;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  pop;

  rr_pick #(
    .N  (NUM_PORTS),
    .IW (SRC_WIDTH)
  ) u_pick (
    .req   (in_has_data),
    .last  (last_grant_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    head_vld = 1'b0;
    head_dat = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == SRC_WIDTH'(p)) begin
        head_vld = in_has_data[p];
        head_dat = in_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gated by rst so that no FIFO word is lost in the reset cycle.
  assign pop = ~rst & (state_q == ST_GRANT) & head_vld & (~out_valid_q | out_ready);

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_rd_en[p] = pop & (grant_q == SRC_WIDTH'(p));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;

    if (state_q == ST_IDLE) begin
      if (pick_found) begin
        grant_d      = pick_idx;
        last_grant_d = pick_idx;
        burst_cnt_d  = '0;
        state_d      = ST_GRANT;
      end
    end else begin
      if (pop) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        if (burst_cnt_q == CW'(BURST - 1)) state_d = ST_IDLE;
      end else if (!head_vld) begin
        state_d = ST_IDLE;
      end
    end

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = head_dat;
      out_src_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_WIDTH'(NUM_PORTS - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == ST_GRANT);

`ifdef FWFT_RR_DRAIN_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_PORTS];
  logic [STAT_WIDTH-1:0] stat_d [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      stat_d[p] = stat_q[p] + STAT_WIDTH'(in_rd_en[p]);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst) stat_q[p] <= '0;
      else     stat_q[p] <= stat_d[p];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign stat_words[g*STAT_WIDTH +: STAT_WIDTH] = stat_q[g];
  end
`endif

endmodule
